// File: rtl/spike_delay_line.sv
// Programmable long-latency delay for a 1-bit spike train sampled once per tick.
// Circular 1-bit buffer with a FILL/RUN state machine and a load/ack handshake.
module spike_delay_line #(
    parameter int ADDR_W    = 10,
    parameter int MAX_DELAY = 2**ADDR_W - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_en,
    input  logic              spike_in,
    input  logic [ADDR_W-1:0] delay_in,
    input  logic              delay_load,
    output logic              load_ack,
    output logic              spike_out,
    output logic              spike_combined,
    output logic              filled,
    output logic              delay_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0]   MAX_D = (ADDR_W+1)'(MAX_DELAY);
    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

    typedef enum logic {FILL, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] delay_q;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bit;
    logic              over_max;
    logic              wr_en;

    logic mem [DEPTH];

    // Read address is modular; for delay_q >= 1 it never aliases the write slot.
    assign rd_addr  = wr_ptr - delay_q;
    assign rd_bit   = mem[rd_addr];
    assign over_max = {1'b0, delay_in} > MAX_D;
    assign wr_en    = tick_en && !delay_load && !reset;

    // Storage is left unreset; stale contents are masked while in FILL.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= spike_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= FILL;
            wr_ptr         <= '0;
            fill_cnt       <= '0;
            delay_q        <= '0;
            load_ack       <= 1'b0;
            spike_out      <= 1'b0;
            spike_combined <= 1'b0;
            filled         <= 1'b0;
            delay_err      <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (delay_load) begin
                // A load coinciding with a tick drops that tick's sample.
                delay_q   <= over_max ? MAX_D[ADDR_W-1:0] : delay_in;
                delay_err <= over_max;
                fill_cnt  <= '0;
                state     <= FILL;
                filled    <= 1'b0;
                load_ack  <= 1'b1;
            end else if (tick_en) begin
                wr_ptr <= wr_ptr + ONE;
                if (delay_q == '0) begin
                    spike_out      <= spike_in;
                    spike_combined <= spike_in;
                    state          <= RUN;
                    filled         <= 1'b1;
                end else if (state == FILL) begin
                    spike_out      <= 1'b0;
                    spike_combined <= spike_in;
                    fill_cnt       <= fill_cnt + ONE;
                    if (fill_cnt + ONE == delay_q) begin
                        state  <= RUN;
                        filled <= 1'b1;
                    end
                end else begin
                    spike_out      <= rd_bit;
                    spike_combined <= spike_in | rd_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_delay_line.sv
// Directed/randomized bench for spike_delay_line against a tick-history model.
// DUT built with ADDR_W=5, MAX_DELAY=15 so an over-range delay_in (20) is representable.
module tb_spike_delay_line;

    localparam int AW   = 5;
    localparam int MAXD = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick_en;
    logic          spike_in;
    logic [AW-1:0] delay_in;
    logic          delay_load;
    logic          load_ack;
    logic          spike_out;
    logic          spike_combined;
    logic          filled;
    logic          delay_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: samples accepted since the last load/reset, plus expected outputs.
    int m_d;
    bit hist[$];
    bit m_out, m_comb, m_filled, m_ack, m_err;

    spike_delay_line #(.ADDR_W(AW), .MAX_DELAY(MAXD)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_en        (tick_en),
        .spike_in       (spike_in),
        .delay_in       (delay_in),
        .delay_load     (delay_load),
        .load_ack       (load_ack),
        .spike_out      (spike_out),
        .spike_combined (spike_combined),
        .filled         (filled),
        .delay_err      (delay_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, ".spike_out"},      spike_out,      m_out);
        chk({ctx, ".spike_combined"}, spike_combined, m_comb);
        chk({ctx, ".filled"},         filled,         m_filled);
        chk({ctx, ".load_ack"},       load_ack,       m_ack);
        chk({ctx, ".delay_err"},      delay_err,      m_err);
    endtask

    // One clock cycle with the given inputs, then model update and full check.
    task automatic step(input string ctx, input bit tk, input bit sp, input bit ld, input int d);
        int k;
        tick_en    = tk;
        spike_in   = sp;
        delay_load = ld;
        delay_in   = d[AW-1:0];
        @(posedge clk); #1;
        tick_en    = 1'b0;
        delay_load = 1'b0;
        spike_in   = 1'b0;
        m_ack = 1'b0;
        if (ld) begin
            m_err    = (d > MAXD);
            m_d      = (d > MAXD) ? MAXD : d;
            m_ack    = 1'b1;
            m_filled = 1'b0;
            hist.delete();
        end else if (tk) begin
            hist.push_back(sp);
            k = hist.size();
            if (m_d == 0)      m_out = sp;
            else if (k <= m_d) m_out = 1'b0;
            else               m_out = hist[k-1-m_d];
            m_comb   = sp | m_out;
            m_filled = (k >= ((m_d == 0) ? 1 : m_d));
        end
        check_all(ctx);
    endtask

    task automatic do_reset(input string ctx);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_d = 0; m_err = 0; m_out = 0; m_comb = 0; m_filled = 0; m_ack = 0;
        hist.delete();
        check_all(ctx);
    endtask

    task automatic tick(input string ctx, input bit sp, input int gap);
        step(ctx, 1'b1, sp, 1'b0, 0);
        for (int g = 0; g < gap; g++) step({ctx, ".idle"}, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b0; tick_en = 1'b0; spike_in = 1'b0; delay_in = '0; delay_load = 1'b0;
        @(posedge clk); #1;

        do_reset("reset");

        // Impulse at delay 5, tick every 4 cycles.
        step("load5", 1'b0, 1'b0, 1'b1, 5);
        for (int t = 0; t < 10; t++) tick("d5", (t == 0), 3);

        // Pass-through at delay 0 with random spikes and gaps.
        step("load0", 1'b0, 1'b0, 1'b1, 0);
        for (int t = 0; t < 50; t++) tick("d0", 1'($urandom), $urandom_range(0, 2));

        // Delay 15 with periodic input; 200 ticks wraps a 32-entry buffer 6 times.
        step("load15", 1'b0, 1'b0, 1'b1, 15);
        for (int t = 0; t < 200; t++) tick("d15", (t % 3 == 0), $urandom_range(0, 1));

        // Over-range delay clamps to MAX_DELAY and flags; next legal load clears it.
        step("load20", 1'b0, 1'b0, 1'b1, 20);
        for (int t = 0; t < 20; t++) tick("d20", (t == 0), 1);
        step("load3", 1'b0, 1'b0, 1'b1, 3);
        for (int t = 0; t < 8; t++) tick("d3", (t == 0), 1);

        // Reload mid-RUN coinciding with a tick: that sample is dropped.
        step("load8", 1'b0, 1'b0, 1'b1, 8);
        for (int t = 0; t < 20; t++) tick("d8", 1'($urandom), $urandom_range(0, 1));
        step("reload2", 1'b1, 1'b1, 1'b1, 2);
        for (int t = 0; t < 12; t++) tick("d2", 1'($urandom), $urandom_range(0, 1));

        // Back-to-back loads, each acknowledged.
        step("b2b4", 1'b0, 1'b0, 1'b1, 4);
        step("b2b6", 1'b0, 1'b0, 1'b1, 6);
        for (int t = 0; t < 10; t++) tick("d6", 1'($urandom), 0);

        // Reset while in RUN with spike_out high, then delay-0 pass-through.
        step("load1", 1'b0, 1'b0, 1'b1, 1);
        tick("d1a", 1'b1, 0);
        tick("d1b", 1'b0, 2);
        do_reset("reset_run");
        tick("post_reset", 1'b1, 1);
        tick("post_reset2", 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
